// File: rtl/simd_job_sched.sv
// Job scheduler for the SIMD core. Two requesters post jobs, a round-robin arbiter picks one,
// then the block issues it, streams its operand beats, waits for the core to drain and pulses done.
module simd_job_sched #(
  parameter int DATA_W  = 128,
  parameter int INSTR_W = 3,
  parameter int SIZE_W  = 6,
  parameter int LAT     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic [SIZE_W-1:0]  req0_size,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [INSTR_W-1:0] req1_instr,
  input  logic [SIZE_W-1:0]  req1_size,
  output logic               req1_ready,
  input  logic               opnd_valid,
  input  logic [DATA_W-1:0]  opnd_a,
  input  logic [DATA_W-1:0]  opnd_b,
  output logic               opnd_ready,
  output logic               simd_valid_instruction,
  output logic [INSTR_W-1:0] simd_instruction,
  output logic [SIZE_W-1:0]  simd_data_size,
  output logic               simd_valid_data,
  output logic [DATA_W-1:0]  simd_opa,
  output logic [DATA_W-1:0]  simd_opb,
  output logic               busy,
  output logic               done,
  output logic               done_id
);

  localparam int DW = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [SIZE_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic                vdata_q, vdata_d;

  logic                grant0, grant1, in_idle, beat;

  // Tie goes to the requester that was not granted last time.
  always_comb begin
    grant1  = req1_valid && (!req0_valid || !last_grant_q);
    grant0  = req0_valid && !grant1;
    in_idle = (state_q == S_IDLE) && reset;
    beat    = (state_q == S_STREAM) && opnd_valid;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    instr_d      = instr_q;
    size_d       = size_q;
    beat_cnt_d   = beat_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    vdata_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          instr_d      = grant1 ? req1_instr : req0_instr;
          size_d       = grant1 ? req1_size : req0_size;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        beat_cnt_d  = '0;
        drain_cnt_d = '0;
        state_d     = (size_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (beat) begin
          opa_d   = opnd_a;
          opb_d   = opnd_b;
          vdata_d = 1'b1;
          if (beat_cnt_q == size_q - SIZE_W'(1)) begin
            beat_cnt_d = '0;
            state_d    = S_DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset clears the operand registers too, so an aborted job leaves nothing on the core bus.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      instr_q      <= '0;
      size_q       <= '0;
      beat_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      vdata_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      instr_q      <= instr_d;
      size_q       <= size_d;
      beat_cnt_q   <= beat_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      vdata_q      <= vdata_d;
    end
  end

  always_comb begin
    req0_ready             = in_idle && grant0;
    req1_ready             = in_idle && grant1;
    opnd_ready             = (state_q == S_STREAM);
    simd_valid_instruction = (state_q == S_ISSUE);
    simd_instruction       = (state_q != S_IDLE) ? instr_q : '0;
    simd_data_size         = (state_q != S_IDLE) ? size_q : '0;
    simd_valid_data        = vdata_q;
    simd_opa               = opa_q;
    simd_opb               = opb_q;
    busy                   = (state_q != S_IDLE);
    done                   = (state_q == S_DONE);
    done_id                = (state_q == S_DONE) && owner_q;
  end

endmodule

// File: tb/tb_simd_job_sched.sv
// Bench for simd_job_sched: job table, reset/abort sequences and random jobs checked against
// a timeline model (grant order, beat stream, done cycle derived from size, stalls and LAT).
module tb_simd_job_sched;
  localparam int DATA_W  = 128;
  localparam int INSTR_W = 3;
  localparam int SIZE_W  = 6;
  localparam int LAT     = 4;
  localparam logic [127:0] CONSTV = 128'h11111111_22222222_55555555_66666666;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic [INSTR_W-1:0] req0_instr = '0, req1_instr = '0;
  logic [SIZE_W-1:0]  req0_size = '0, req1_size = '0;
  logic               req0_ready, req1_ready;
  logic               opnd_valid = 1'b0;
  logic [DATA_W-1:0]  opnd_a = '0, opnd_b = '0;
  logic               opnd_ready;
  logic               simd_valid_instruction, simd_valid_data;
  logic [INSTR_W-1:0] simd_instruction;
  logic [SIZE_W-1:0]  simd_data_size;
  logic [DATA_W-1:0]  simd_opa, simd_opb;
  logic               busy, done, done_id;

  simd_job_sched #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .SIZE_W(SIZE_W), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_instr(req0_instr), .req0_size(req0_size), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_instr(req1_instr), .req1_size(req1_size), .req1_ready(req1_ready),
    .opnd_valid(opnd_valid), .opnd_a(opnd_a), .opnd_b(opnd_b), .opnd_ready(opnd_ready),
    .simd_valid_instruction(simd_valid_instruction), .simd_instruction(simd_instruction),
    .simd_data_size(simd_data_size), .simd_valid_data(simd_valid_data),
    .simd_opa(simd_opa), .simd_opb(simd_opb),
    .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               v0, v1;
    logic [INSTR_W-1:0] i0, i1;
    logic [SIZE_W-1:0]  s0, s1;
    int               pct, st_at, st_len;
    int               exp_w;    // expected first winner
    int               exp_off;  // expected cycles from accept to done, -1 when random stalls
  } vec_t;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int lg_m = 1;
  logic [127:0] eopa = '0, eopb = '0;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_r0rdy"}, req0_ready, 0);
    chk({tag, "_r1rdy"}, req1_ready, 0);
    chk({tag, "_ordy"}, opnd_ready, 0);
    chk({tag, "_vinstr"}, simd_valid_instruction, 0);
    chk({tag, "_instr"}, simd_instruction, 0);
    chk({tag, "_dsize"}, simd_data_size, 0);
    chk({tag, "_vdata"}, simd_valid_data, 0);
    chk({tag, "_opa"}, simd_opa, 0);
    chk({tag, "_opb"}, simd_opb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_doneid"}, done_id, 0);
  endtask

  // Entered just after the accept-cycle sample; returns after the done-cycle sample.
  task automatic serve(input int who, input logic [INSTR_W-1:0] instr, input logic [SIZE_W-1:0] size,
                       input int pct, input int st_at, input int st_len, input bit cdat,
                       input int exp_off);
    int a, beats, stalls, consec, run;
    bit prev_take, v;
    logic [127:0] da, db;
    a = cyc; beats = 0; stalls = 0; consec = 0; run = 0; prev_take = 0;
    lg_m = who;
    tick();
    if (who == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    opnd_valid = 1'b1;
    opnd_a = rnd128(); opnd_b = rnd128();
    #1;
    chk("issue_vinstr", simd_valid_instruction, 1);
    chk("issue_instr", simd_instruction, instr);
    chk("issue_size", simd_data_size, size);
    chk("issue_ordy", opnd_ready, 0);
    chk("issue_vdata", simd_valid_data, 0);
    chk("issue_busy", busy, 1);
    chk("issue_rdy", {req0_ready, req1_ready}, 0);
    while (beats < int'(size)) begin
      tick();
      if (beats == st_at && run < st_len) begin v = 0; run++; end
      else if (consec < 3 && $urandom_range(99) < pct) v = 0;
      else v = 1;
      da = cdat ? CONSTV : rnd128();
      db = cdat ? CONSTV : rnd128();
      opnd_valid = v; opnd_a = da; opnd_b = db;
      #1;
      chk("strm_ordy", opnd_ready, 1);
      chk("strm_vdata", simd_valid_data, prev_take);
      chk("strm_opa", simd_opa, eopa);
      chk("strm_opb", simd_opb, eopb);
      chk("strm_vinstr", simd_valid_instruction, 0);
      chk("strm_instr", {simd_instruction, simd_data_size}, {instr, size});
      chk("strm_done", done, 0);
      chk("strm_rdy", {req0_ready, req1_ready}, 0);
      if (v) begin
        eopa = da; eopb = db; beats++; prev_take = 1; consec = 0;
      end else begin
        prev_take = 0; stalls++; consec++;
      end
    end
    for (int i = 0; i < LAT; i++) begin
      tick();
      opnd_valid = 1'b1; opnd_a = rnd128(); opnd_b = rnd128();
      #1;
      chk("drn_ordy", opnd_ready, 0);
      chk("drn_vdata", simd_valid_data, (i == 0) && prev_take);
      chk("drn_opa", simd_opa, eopa);
      chk("drn_opb", simd_opb, eopb);
      chk("drn_done", done, 0);
      chk("drn_busy", busy, 1);
      chk("drn_instr", {simd_instruction, simd_data_size}, {instr, size});
      chk("drn_rdy", {req0_ready, req1_ready}, 0);
    end
    tick();
    opnd_valid = 1'b0;
    #1;
    chk("done_pulse", done, 1);
    chk("done_id", done_id, who[0]);
    chk("done_busy", busy, 1);
    chk("done_vdata", simd_valid_data, 0);
    chk("done_ordy", opnd_ready, 0);
    chk("done_rdy", {req0_ready, req1_ready}, 0);
    chk("done_instr", {simd_instruction, simd_data_size}, {instr, size});
    chk("done_cycle", cyc - a, ((size == 0) ? 2 : 2 + int'(size) + stalls) + LAT);
    if (exp_off >= 0) chk("done_offset", cyc - a, exp_off);
  endtask

  task automatic job_pair(input vec_t t, input bit cdat);
    int w, l;
    tick();
    req0_valid = t.v0; req0_instr = t.i0; req0_size = t.s0;
    req1_valid = t.v1; req1_instr = t.i1; req1_size = t.s1;
    #1;
    if (t.exp_w >= 0) w = t.exp_w;
    else w = (t.v0 && t.v1) ? ((lg_m == 1) ? 0 : 1) : (t.v0 ? 0 : 1);
    l = 1 - w;
    chk("acc_r0rdy", req0_ready, w == 0);
    chk("acc_r1rdy", req1_ready, w == 1);
    chk("acc_busy", busy, 0);
    chk("acc_done", done, 0);
    if (w == 0) serve(0, t.i0, t.s0, t.pct, t.st_at, t.st_len, cdat, t.exp_off);
    else        serve(1, t.i1, t.s1, t.pct, t.st_at, t.st_len, cdat, t.exp_off);
    if (t.v0 && t.v1) begin
      tick();
      #1;
      chk("wait_rdy_loser", (l == 0) ? req0_ready : req1_ready, 1);
      chk("wait_rdy_winner", (w == 0) ? req0_ready : req1_ready, 0);
      chk("wait_busy", busy, 0);
      if (l == 0) serve(0, t.i0, t.s0, t.pct, t.st_at, t.st_len, cdat, -1);
      else        serve(1, t.i1, t.s1, t.pct, t.st_at, t.st_len, cdat, -1);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_rdy", {req0_ready, req1_ready}, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t r;
    tbl[0] = '{1, 1, 3'd1, 3'd2, 6'd2, 6'd2, 0, -1, 0, 0, 8};
    tbl[1] = '{1, 1, 3'd3, 3'd4, 6'd2, 6'd2, 0, -1, 0, 0, 8};
    tbl[2] = '{1, 0, 3'd0, 3'd0, 6'd3, 6'd0, 0, -1, 0, 0, 9};
    tbl[3] = '{0, 1, 3'd0, 3'd5, 6'd0, 6'd3, 0, 1, 2, 1, 11};
    tbl[4] = '{1, 0, 3'd6, 3'd0, 6'd0, 6'd0, 0, -1, 0, 0, 6};
    tbl[5] = '{1, 1, 3'd7, 3'd2, 6'd1, 6'd0, 0, -1, 0, 1, 6};
    tbl[6] = '{0, 1, 3'd0, 3'd3, 6'd0, 6'd5, 40, -1, 0, 1, -1};

    for (int i = 0; i < 5; i++) tick();
    #1;
    chk_all_zero("rst");
    tick();
    reset = 1'b1;

    for (int i = 0; i < 7; i++) job_pair(tbl[i], 1'b0);

    // Abort in STREAM after one of four beats.
    tick();
    req0_valid = 1'b1; req0_instr = 3'd5; req0_size = 6'd4;
    #1;
    chk("abort_acc", req0_ready, 1);
    tick(); req0_valid = 1'b0;
    tick(); opnd_valid = 1'b1; opnd_a = rnd128(); opnd_b = rnd128();
    tick(); reset = 1'b0; opnd_a = rnd128();
    tick(); reset = 1'b1; opnd_valid = 1'b0;
    #1;
    chk_all_zero("abort");
    lg_m = 1; eopa = '0; eopb = '0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      #1;
      chk("abort_nodone", done, 0);
    end
    r = '{1, 0, 3'd2, 3'd0, 6'd2, 6'd0, 0, -1, 0, 0, 8};
    job_pair(r, 1'b0);

    // Maximum size with a constant operand on every beat.
    r = '{1, 0, 3'd4, 3'd0, 6'd63, 6'd0, 0, -1, 0, 0, 2 + 63 + LAT};
    job_pair(r, 1'b1);

    for (int k = 0; k < 25; k++) begin
      r.v0 = 1'($urandom_range(1));
      r.v1 = 1'($urandom_range(1));
      if (!r.v0 && !r.v1) r.v0 = 1'b1;
      r.i0 = 3'($urandom); r.i1 = 3'($urandom);
      r.s0 = 6'($urandom_range(12)); r.s1 = 6'($urandom_range(12));
      r.pct = $urandom_range(50);
      r.st_at = -1; r.st_len = 0;
      r.exp_w = -1; r.exp_off = -1;
      job_pair(r, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
